// File: rtl/aes_pkg.sv
// Shared AES definitions: scheduler FSM states, requester ids, widths and
// GF(2^8) helpers used to build the S-box lanes.
package aes_pkg;
  localparam int AES_WORD_W  = 32;
  localparam int AES_STATE_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  localparam logic REQ_KS = 1'b0;
  localparam logic REQ_RD = 1'b1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_sbox_lane_bank.sv
// Bank of LANES combinational S-boxes sharing one forward/inverse select.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       decode,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = decode ? sbox_inv(din) : sbox_fwd(din);
endmodule

module aes_sbox_lane_bank #(
  parameter int LANES = 4
) (
  input  logic               decode,
  input  logic [LANES*8-1:0] din,
  output logic [LANES*8-1:0] dout
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .decode (decode),
      .din    (din[8*g +: 8]),
      .dout   (dout[8*g +: 8])
    );
  end
endmodule

// File: rtl/aes_sbox_scheduler.sv
// Arbitrates key-schedule SubWord and round SubBytes jobs onto a shared S-box
// lane bank, sequencing LANES bytes per beat and returning registered results.
module aes_sbox_scheduler
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ks_req_valid,
  output logic                   ks_req_ready,
  input  logic [AES_WORD_W-1:0]  ks_req_word,
  output logic                   ks_rsp_valid,
  input  logic                   ks_rsp_ready,
  output logic [AES_WORD_W-1:0]  ks_rsp_word,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic                   rd_req_decode,
  input  logic [AES_STATE_W-1:0] rd_req_state,
  output logic                   rd_rsp_valid,
  input  logic                   rd_rsp_ready,
  output logic [AES_STATE_W-1:0] rd_rsp_state,
  output logic                   busy
);
  localparam int LW     = 8 * LANES;
  localparam int NBEATS = AES_STATE_W / LW;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  state_e                 state_q;
  logic                   last_grant_q;  // also identifies the job in flight
  logic                   decode_q;
  logic [BW-1:0]          beat_q;
  logic [AES_STATE_W-1:0] op_q;
  logic [AES_STATE_W-1:0] res_q;
  logic [AES_STATE_W-1:0] res_d;
  logic [LW-1:0]          lane_in;
  logic [LW-1:0]          lane_out;
  logic                   ks_win;
  logic                   rd_win;
  logic                   last_beat;
  logic                   rsp_take;

  // Round-robin tie-break: on contention the requester not granted last wins.
  always_comb begin
    ks_win = ks_req_valid && (!rd_req_valid || last_grant_q == REQ_RD);
    rd_win = rd_req_valid && (!ks_req_valid || last_grant_q == REQ_KS);
  end

  // Ready is gated by rst_n so every output is low while reset is held.
  assign ks_req_ready = rst_n && (state_q == IDLE) && ks_win;
  assign rd_req_ready = rst_n && (state_q == IDLE) && rd_win;

  assign busy         = (state_q != IDLE);
  assign ks_rsp_valid = (state_q == RESP) && (last_grant_q == REQ_KS);
  assign rd_rsp_valid = (state_q == RESP) && (last_grant_q == REQ_RD);
  assign ks_rsp_word  = ks_rsp_valid ? res_q[AES_WORD_W-1:0] : '0;
  assign rd_rsp_state = rd_rsp_valid ? res_q : '0;

  // A KS job is a single beat; its operand upper bytes are zero so spare lanes see 0.
  assign last_beat = (last_grant_q == REQ_KS) || (beat_q == BW'(NBEATS - 1));
  assign rsp_take  = (last_grant_q == REQ_KS) ? ks_rsp_ready : rd_rsp_ready;

  // Operand mux for the current beat and result writeback into the beat's slot.
  always_comb begin
    lane_in = op_q[int'(beat_q) * LW +: LW];
    res_d   = res_q;
    res_d[int'(beat_q) * LW +: LW] = lane_out;
  end

  aes_sbox_lane_bank #(.LANES(LANES)) u_bank (
    .decode (decode_q),
    .din    (lane_in),
    .dout   (lane_out)
  );

  // Scheduler FSM: accept in IDLE, one beat per cycle in RUN, hold result in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_RD;
      decode_q     <= 1'b0;
      beat_q       <= '0;
      op_q         <= '0;
      res_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ks_req_ready) begin
            op_q         <= {{(AES_STATE_W - AES_WORD_W){1'b0}}, ks_req_word};
            decode_q     <= 1'b0;
            last_grant_q <= REQ_KS;
            beat_q       <= '0;
            state_q      <= RUN;
          end else if (rd_req_ready) begin
            op_q         <= rd_req_state;
            decode_q     <= rd_req_decode;
            last_grant_q <= REQ_RD;
            beat_q       <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          res_q <= res_d;
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= RESP;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        RESP: if (rsp_take) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Bench for aes_sbox_scheduler: transaction-level model with a per-cycle compare
// process on a LANES=4 instance, directed literal cases, and a LANES=16 instance.
module tb_aes_sbox_scheduler;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         ks_req_valid, ks_req_ready, ks_rsp_valid, ks_rsp_ready;
  logic [31:0]  ks_req_word, ks_rsp_word;
  logic         rd_req_valid, rd_req_ready, rd_req_decode, rd_rsp_valid, rd_rsp_ready, busy;
  logic [127:0] rd_req_state, rd_rsp_state;

  logic         s_ks_req_valid, s_ks_req_ready, s_ks_rsp_valid, s_ks_rsp_ready;
  logic [31:0]  s_ks_req_word, s_ks_rsp_word;
  logic         s_rd_req_valid, s_rd_req_ready, s_rd_req_decode, s_rd_rsp_valid, s_rd_rsp_ready, s_busy;
  logic [127:0] s_rd_req_state, s_rd_rsp_state;

  aes_sbox_scheduler #(.LANES(L)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_req_word(ks_req_word),
    .ks_rsp_valid(ks_rsp_valid), .ks_rsp_ready(ks_rsp_ready), .ks_rsp_word(ks_rsp_word),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_decode(rd_req_decode),
    .rd_req_state(rd_req_state), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_state(rd_rsp_state), .busy(busy)
  );

  aes_sbox_scheduler #(.LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .ks_req_valid(s_ks_req_valid), .ks_req_ready(s_ks_req_ready), .ks_req_word(s_ks_req_word),
    .ks_rsp_valid(s_ks_rsp_valid), .ks_rsp_ready(s_ks_rsp_ready), .ks_rsp_word(s_ks_rsp_word),
    .rd_req_valid(s_rd_req_valid), .rd_req_ready(s_rd_req_ready), .rd_req_decode(s_rd_req_decode),
    .rd_req_state(s_rd_req_state), .rd_rsp_valid(s_rd_rsp_valid), .rd_rsp_ready(s_rd_rsp_ready),
    .rd_rsp_state(s_rd_rsp_state), .busy(s_busy)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box tables from generator-3 walk of GF(2^8): p steps by *3, q by /3.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      fwd_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model_sub(input bit rd, input bit dec, input logic [127:0] op);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < (rd ? 16 : 4); i++)
      r[8*i +: 8] = (rd && dec) ? inv_t[op[8*i +: 8]] : fwd_t[op[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [255:0] outs4();
    return {ks_req_ready, rd_req_ready, ks_rsp_valid, rd_rsp_valid, busy, ks_rsp_word, rd_rsp_state};
  endfunction

  // Transaction model: one job in flight, result visible beats(owner) edges after acceptance.
  bit m_act, m_own, m_last;
  logic [127:0] m_res;
  int m_c;

  initial begin
    bit acc_ks, acc_rd, done, eksr, erdr;
    logic [127:0] nres, ers;
    logic [31:0] ekw;
    bit eksv, erdv;
    m_act = 0; m_last = 1; m_own = 0; m_c = 0; m_res = '0; nres = '0;
    forever begin
      @(negedge clk);
      acc_ks = 0; acc_rd = 0; done = 0;
      if (!rst_n) begin
        m_act = 0; m_last = 1;
        chk("reset_outputs", outs4(), '0);
      end else begin
        eksr = 0; erdr = 0; eksv = 0; erdv = 0; ekw = '0; ers = '0;
        if (!m_act) begin
          eksr = ks_req_valid && (!rd_req_valid || m_last);
          erdr = rd_req_valid && (!ks_req_valid || !m_last);
        end else if (m_c >= (m_own ? 16 / L : 1)) begin
          if (m_own) begin erdv = 1; ers = m_res; end
          else begin eksv = 1; ekw = m_res[31:0]; end
        end
        chk("cycle", outs4(), {eksr, erdr, eksv, erdv, m_act, ekw, ers});
        if (!m_act) begin
          acc_ks = eksr; acc_rd = erdr;
          nres = acc_ks ? model_sub(0, 0, {96'b0, ks_req_word}) : model_sub(1, rd_req_decode, rd_req_state);
        end else begin
          done = (m_c >= (m_own ? 16 / L : 1)) && (m_own ? rd_rsp_ready : ks_rsp_ready);
        end
      end
      @(posedge clk);
      if (acc_ks || acc_rd) begin
        m_act = 1; m_own = acc_rd; m_last = acc_rd; m_res = nres; m_c = 0;
      end else if (done) m_act = 0;
      else if (m_act) m_c++;
    end
  end

  task automatic run_job(input string nm, input bit rd, input bit dec, input logic [127:0] op,
                         input logic [127:0] exp, input int exp_lat);
    int n;
    ks_rsp_ready = 0; rd_rsp_ready = 0;
    if (rd) begin rd_req_valid = 1; rd_req_decode = dec; rd_req_state = op; end
    else begin ks_req_valid = 1; ks_req_word = op[31:0]; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(rd ? rd_req_ready : ks_req_ready) && n < 50);
    chk({nm, "_accept"}, (n < 50), 1);
    @(posedge clk); #1;
    rd_req_valid = 0; ks_req_valid = 0;
    ks_req_word = $urandom; rd_req_state = {$urandom, $urandom, $urandom, $urandom};
    rd_req_decode = ~dec;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rd ? rd_rsp_valid : ks_rsp_valid) && n < 50);
    chk({nm, "_lat"}, n - 1, exp_lat);
    chk({nm, "_data"}, rd ? rd_rsp_state : {96'b0, ks_rsp_word}, exp);
    if (rd) rd_rsp_ready = 1; else ks_rsp_ready = 1;
    @(posedge clk); #1;
    ks_rsp_ready = 0; rd_rsp_ready = 0;
  endtask

  task automatic job16(input string nm, input bit rd, input logic [127:0] op, input logic [127:0] exp);
    int n;
    s_ks_rsp_ready = 0; s_rd_rsp_ready = 0;
    if (rd) begin s_rd_req_valid = 1; s_rd_req_decode = 0; s_rd_req_state = op; end
    else begin s_ks_req_valid = 1; s_ks_req_word = op[31:0]; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(rd ? s_rd_req_ready : s_ks_req_ready) && n < 50);
    chk({nm, "_accept"}, (n < 50), 1);
    @(posedge clk); #1;
    s_rd_req_valid = 0; s_ks_req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rd ? s_rd_rsp_valid : s_ks_rsp_valid) && n < 50);
    chk({nm, "_lat"}, n - 1, 1);
    chk({nm, "_data"}, rd ? s_rd_rsp_state : {96'b0, s_ks_rsp_word}, exp);
    if (rd) s_rd_rsp_ready = 1; else s_ks_rsp_ready = 1;
    @(posedge clk); #1;
    s_ks_rsp_ready = 0; s_rd_rsp_ready = 0;
  endtask

  initial begin
    int n;
    logic [127:0] op3, exp3, snap;
    build_tables();
    // Pin the model against hand-computed values.
    chk("tbl_fwd_00", fwd_t[8'h00], 8'h63);
    chk("tbl_fwd_53", fwd_t[8'h53], 8'hed);
    chk("tbl_inv_7c", inv_t[8'h7c], 8'h01);
    s_ks_req_valid = 0; s_ks_req_word = '0; s_ks_rsp_ready = 0;
    s_rd_req_valid = 0; s_rd_req_decode = 0; s_rd_req_state = '0; s_rd_rsp_ready = 0;
    // Both requesting while reset is held: nothing may be accepted.
    ks_req_valid = 1; ks_req_word = $urandom; ks_rsp_ready = 1;
    rd_req_valid = 1; rd_req_decode = 0; rd_req_state = {$urandom, $urandom, $urandom, $urandom};
    rd_rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Contention: KS first after reset, then alternation while both stay valid.
    @(negedge clk);
    chk("arb_first_ks", {ks_req_ready, rd_req_ready}, 2'b10);
    for (int j = 0; j < 3; j++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(ks_rsp_valid || rd_rsp_valid) && n < 50);
      chk("arb_order", {ks_rsp_valid, rd_rsp_valid}, (j == 1) ? 2'b01 : 2'b10);
      @(posedge clk);
    end
    #1 ks_req_valid = 0; rd_req_valid = 0; ks_rsp_ready = 0; rd_rsp_ready = 0;
    @(posedge clk); #1;

    run_job("ks_word", 0, 0, 128'h63530100, 128'hfbed7c63, 1);
    run_job("rd_fwd_zero", 1, 0, '0, {16{8'h63}}, 4);
    op3 = {16{8'h63}}; op3[47:40] = 8'h7c;
    exp3 = '0; exp3[47:40] = 8'h01;
    run_job("rd_inv", 1, 1, op3, exp3, 4);

    // Backpressure: response and state hold, no new acceptance.
    rd_req_valid = 1; rd_req_decode = 0; rd_req_state = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_req_ready && n < 50);
    @(posedge clk); #1 ks_req_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_rsp_valid && n < 50);
    snap = rd_rsp_state;
    repeat (10) begin
      @(negedge clk);
      chk("hold_data", rd_rsp_state, snap);
      chk("hold_ready", {ks_req_ready, rd_req_ready, rd_rsp_valid}, 3'b001);
    end
    @(posedge clk); #1 rd_rsp_ready = 1; ks_req_valid = 0; rd_req_valid = 0;
    @(posedge clk); #1 rd_rsp_ready = 0;
    @(negedge clk);
    chk("hold_release_idle", busy, 0);

    // Reset during beat 2 of an RD job drops it.
    @(posedge clk); #1;
    rd_req_valid = 1; rd_req_decode = 0; rd_req_state = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_req_ready && n < 50);
    @(posedge clk); #1 rd_req_valid = 0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 0;
    #1 chk("rst_mid_outputs", outs4(), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) begin @(negedge clk); chk("rst_no_rsp", rd_rsp_valid, 0); end
    @(posedge clk); #1;
    run_job("ks_after_rst", 0, 0, 128'h63530100, 128'hfbed7c63, 1);

    // Wide bank: both job types finish in one beat.
    job16("l16_ks", 0, 128'h63530100, 128'hfbed7c63);
    job16("l16_rd", 1, '0, {16{8'h63}});

    // Randomized traffic on the LANES=4 instance, checked by the model each cycle.
    repeat (1500) begin
      @(posedge clk); #1;
      ks_req_valid  = ($urandom_range(0, 3) != 0);
      ks_req_word   = $urandom;
      rd_req_valid  = ($urandom_range(0, 3) != 0);
      rd_req_decode = 1'($urandom_range(0, 1));
      rd_req_state  = {$urandom, $urandom, $urandom, $urandom};
      ks_rsp_ready  = ($urandom_range(0, 2) != 0);
      rd_rsp_ready  = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    ks_req_valid = 0; rd_req_valid = 0; ks_rsp_ready = 1; rd_rsp_ready = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
